// File: rtl/vga_pattern_sequencer.sv
// Test-pattern sequencer for a 640x480 VGA pipeline: debounced button or
// timed auto-advance selects one of four patterns, switched only at frame start.
module vga_pattern_sequencer #(
    parameter int DB_CYCLES    = 500000,
    parameter int DWELL_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       auto_en,
    input  logic [2:0] sw,
    input  logic       video_on,
    input  logic       p_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic [2:0] rgb,
    output logic [1:0] pattern
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);

    typedef enum logic {MANUAL, AUTO} state_t;

    state_t        state, state_nx;
    logic          btn_s1, btn_s2;
    logic [CW-1:0] db_cnt;
    logic          db_level;
    logic          armed;
    logic          press;
    logic          frame_start;
    logic [7:0]    frame_cnt, frame_cnt_nx;
    logic [1:0]    next_pat, next_pat_nx;
    logic [2:0]    colour;
    logic          border;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
        end
    end

    // Until a stable release is seen after reset, a held button is never
    // accepted, so it cannot produce a press without being re-pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            armed    <= 1'b0;
        end else if (!armed) begin
            if (btn_s2) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                armed  <= 1'b1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end else if (btn_s2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= btn_s2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press = armed && !db_level && btn_s2
                   && (db_cnt == DB_LAST);

    assign frame_start = p_tick && (pixel_x == 10'd0)
                         && (pixel_y == 10'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= MANUAL;
            frame_cnt <= '0;
            next_pat  <= '0;
        end else begin
            state     <= state_nx;
            frame_cnt <= frame_cnt_nx;
            next_pat  <= next_pat_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        next_pat_nx  = next_pat;
        unique case (state)
            MANUAL: begin
                if (press)
                    next_pat_nx = next_pat + 2'd1;
                if (auto_en) begin
                    state_nx     = AUTO;
                    frame_cnt_nx = '0;
                end
            end
            AUTO: begin
                if (frame_start) begin
                    if (frame_cnt == DWELL_LAST) begin
                        next_pat_nx  = next_pat + 2'd1;
                        frame_cnt_nx = '0;
                    end else begin
                        frame_cnt_nx = frame_cnt + 8'd1;
                    end
                end
                if (!auto_en)
                    state_nx = MANUAL;
            end
        endcase
    end

    assign border = (pixel_x == 10'd0) || (pixel_x == 10'd639)
                    || (pixel_y == 10'd0) || (pixel_y == 10'd479);

    always_comb begin
        colour = 3'b000;
        unique case (pattern)
            2'd0: colour = sw;
            2'd1: colour = pixel_x[8:6];
            2'd2: colour = (pixel_x[5] ^ pixel_y[5]) ? ~sw : sw;
            2'd3: colour = border ? 3'b111 : 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            rgb     <= '0;
        end else begin
            if (frame_start)
                pattern <= next_pat;
            rgb <= video_on ? colour : 3'b000;
        end
    end

endmodule
